// File: rtl/wb_pkg.sv
// wb_pkg: shared types and default sizing for the writeback sequencer.
//   wb_entry_t : one queued register-file write (destination + data)
//   DW, AW     : default data / register-address widths
//   NUM_REGS   : implemented registers; higher addresses are illegal
//   DEPTH      : default writeback queue depth
package wb_pkg;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int NUM_REGS = 12;
    localparam int DEPTH    = 4;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-match search over the occupied part of the
// writeback queue for one read address.
//   entries : queue storage (circular)
//   head    : index of the oldest occupied entry
//   count   : number of occupied entries
//   addr    : register address being read
//   hit     : some occupied entry targets addr
//   data    : data of the youngest matching entry, 0 on miss
module wb_fwd_match #(
    parameter int DEPTH = wb_pkg::DEPTH,
    parameter int DW    = wb_pkg::DW,
    parameter int AW    = wb_pkg::AW
) (
    input  wb_pkg::wb_entry_t          entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              addr,
    output logic                       hit,
    output logic [DW-1:0]              data
);
    import wb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t e;

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        e    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = entries[head + PW'(i)];
            if ((CW'(i) < count) && (e.dest == addr)) begin
                hit  = 1'b1;
                data = e.data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: sole driver of the register-file write port. Accepts
// results from the load path (mem_*) and the ALU path (alu_*), queues them
// in program order (load older than ALU when both arrive together) and
// drains one entry per cycle onto RegWrite/destination/write_data.
// Queued-but-unwritten values are forwarded to two read ports (A/B),
// youngest match first.
//   clk, Reset              : clock, synchronous active-high reset
//   mem_valid/dest/data     : load result, mem_ready acknowledges
//   alu_valid/dest/data     : ALU result, alu_ready acknowledges
//   RegWrite/destination/write_data : register file write port
//   fwd_addrA/B -> fwd_hitA/B, fwd_dataA/B : forwarding lookups
//   count                   : occupied queue entries
//   dest_err                : sticky, an illegal destination was dropped
module reg_writeback #(
    parameter int DEPTH    = wb_pkg::DEPTH,
    parameter int DW       = wb_pkg::DW,
    parameter int AW       = wb_pkg::AW,
    parameter int NUM_REGS = wb_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_dest,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_dest,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic                     RegWrite,
    output logic [AW-1:0]            destination,
    output logic [DW-1:0]            write_data,
    input  logic [AW-1:0]            fwd_addrA,
    input  logic [AW-1:0]            fwd_addrB,
    output logic                     fwd_hitA,
    output logic                     fwd_hitB,
    output logic [DW-1:0]            fwd_dataA,
    output logic [DW-1:0]            fwd_dataB,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dest_err
);
    import wb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      entries [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  cnt;
    logic           err;

    logic mem_fire, alu_fire;
    logic mem_push, alu_push;
    logic pop;

    function automatic logic dest_legal(input logic [AW-1:0] d);
        return int'(d) < NUM_REGS;
    endfunction

    // Acceptance looks only at the start-of-cycle occupancy; the entry
    // draining this cycle does not make room until the next one.
    always_comb begin
        mem_ready = (cnt <= CW'(DEPTH - 1));
        mem_fire  = mem_valid & mem_ready;
        alu_ready = ((cnt + CW'(mem_fire)) <= CW'(DEPTH - 1));
        alu_fire  = alu_valid & alu_ready;
        // Illegal destinations complete the handshake but are not queued.
        mem_push  = mem_fire & dest_legal(mem_dest);
        alu_push  = alu_fire & dest_legal(alu_dest);
        pop       = (cnt != '0);
    end

    // Write port is a pure function of registered state.
    always_comb begin
        RegWrite    = pop;
        destination = pop ? entries[head].dest : '0;
        write_data  = pop ? entries[head].data : '0;
    end

    assign count    = cnt;
    assign dest_err = err;

    // Queue control: pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            tail <= tail + PW'(mem_push) + PW'(alu_push);
            cnt  <= cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            if ((mem_fire & ~dest_legal(mem_dest)) | (alu_fire & ~dest_legal(alu_dest)))
                err <= 1'b1;
        end
    end

    // Queue storage: the load result takes the first free slot, the ALU
    // result the one after it when both are pushed together.
    always_ff @(posedge clk) begin
        if (mem_push)
            entries[tail] <= '{dest: mem_dest, data: mem_data};
        if (alu_push)
            entries[tail + PW'(mem_push)] <= '{dest: alu_dest, data: alu_data};
    end

    wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwd_a (
        .entries (entries),
        .head    (head),
        .count   (cnt),
        .addr    (fwd_addrA),
        .hit     (fwd_hitA),
        .data    (fwd_dataA)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fwd_b (
        .entries (entries),
        .head    (head),
        .count   (cnt),
        .addr    (fwd_addrB),
        .hit     (fwd_hitB),
        .data    (fwd_dataB)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized and directed stimulus for reg_writeback.
// A queue-level model tracks what should be pending; a scoreboard of
// expected register-file writes is filled when results are accepted and
// emptied by a monitor that watches the write port.
module tb_reg_writeback;

    localparam int DEPTH    = 4;
    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int NUM_REGS = 12;
    localparam int CW       = $clog2(DEPTH) + 1;

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } ent_t;

    logic            clk = 1'b0;
    logic            Reset;
    logic            mem_valid, alu_valid;
    logic [AW-1:0]   mem_dest, alu_dest;
    logic [DW-1:0]   mem_data, alu_data;
    logic            mem_ready, alu_ready;
    logic            RegWrite;
    logic [AW-1:0]   destination;
    logic [DW-1:0]   write_data;
    logic [AW-1:0]   fwd_addrA, fwd_addrB;
    logic            fwd_hitA, fwd_hitB;
    logic [DW-1:0]   fwd_dataA, fwd_dataB;
    logic [CW-1:0]   count;
    logic            dest_err;

    reg_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .Reset(Reset),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .RegWrite(RegWrite), .destination(destination), .write_data(write_data),
        .fwd_addrA(fwd_addrA), .fwd_addrB(fwd_addrB),
        .fwd_hitA(fwd_hitA), .fwd_hitB(fwd_hitB),
        .fwd_dataA(fwd_dataA), .fwd_dataB(fwd_dataB),
        .count(count), .dest_err(dest_err)
    );

    always #5 clk = ~clk;

    ent_t mq[$];          // entries pending in the sequencer, oldest first
    ent_t sb[$];          // register-file writes still expected
    logic err_m = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   mem_acc = 1'b0;
    bit   alu_acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] fwd_exp(input logic [AW-1:0] a);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].dest == a) return {1'b1, mq[i].data};
        return '0;
    endfunction

    task automatic model_push(input logic [AW-1:0] d, input logic [DW-1:0] v);
        ent_t e;
        if (int'(d) < NUM_REGS) begin
            e.dest = d;
            e.data = v;
            mq.push_back(e);
            sb.push_back(e);
        end else begin
            err_m = 1'b1;
        end
    endtask

    // One clock cycle: check combinational/registered outputs mid-cycle,
    // then advance the model across the rising edge.
    task automatic tick();
        logic          exp_mr, exp_ar;
        logic [DW:0]   fa, fb;
        @(negedge clk);
        exp_mr = (mq.size() <= DEPTH - 1);
        exp_ar = ((mq.size() + int'(mem_valid && exp_mr)) <= DEPTH - 1);
        fa = fwd_exp(fwd_addrA);
        fb = fwd_exp(fwd_addrB);
        chk("mem_ready", 32'(mem_ready), 32'(exp_mr));
        chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
        chk("count", 32'(count), 32'(mq.size()));
        chk("count_bound", 32'(count <= CW'(DEPTH)), 32'(1));
        chk("dest_err", 32'(dest_err), 32'(err_m));
        chk("RegWrite", 32'(RegWrite), 32'(mq.size() != 0));
        if (mq.size() == 0) begin
            chk("idle_destination", 32'(destination), 32'(0));
            chk("idle_write_data", 32'(write_data), 32'(0));
        end
        chk("fwd_hitA", 32'(fwd_hitA), 32'(fa[DW]));
        chk("fwd_dataA", 32'(fwd_dataA), 32'(fa[DW-1:0]));
        chk("fwd_hitB", 32'(fwd_hitB), 32'(fb[DW]));
        chk("fwd_dataB", 32'(fwd_dataB), 32'(fb[DW-1:0]));
        mem_acc = mem_valid && exp_mr;
        alu_acc = alu_valid && exp_ar;
        @(posedge clk);
        if (Reset) begin
            mq.delete();
            sb.delete();
            err_m = 1'b0;
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (mem_acc) model_push(mem_dest, mem_data);
            if (alu_acc) model_push(alu_dest, alu_data);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Offer one or two results and hold them until each is taken.
    task automatic push_pair(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                             input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat);
        mem_valid = mv; mem_dest = md; mem_data = mdat;
        alu_valid = av; alu_dest = ad; alu_data = adat;
        for (int k = 0; k < 8 && (mem_valid || alu_valid); k++) begin
            tick();
            if (mem_acc) mem_valid = 1'b0;
            if (alu_acc) alu_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: every write the DUT presents must be the oldest
    // outstanding expected write.
    always @(negedge clk) begin
        ent_t e;
        if (mon_en && Reset === 1'b0 && RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got dest %0d data %0h, expected no write", destination, write_data);
            end else begin
                e = sb.pop_front();
                chk("wr_dest", 32'(destination), 32'(e.dest));
                chk("wr_data", 32'(write_data), 32'(e.data));
            end
        end
    end

    initial begin
        Reset = 1'b1;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        fwd_addrA = '0; fwd_addrB = 4'd3;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        Reset = 1'b0;
        idle(1);

        // single ALU result
        push_pair(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h5A);
        idle(2);

        // same-cycle load and ALU to one register; A looks it up
        fwd_addrA = 4'd2;
        push_pair(1'b1, 4'd2, 8'h11, 1'b1, 4'd2, 8'h22);
        idle(3);

        // fill under sustained dual push
        fwd_addrA = 4'd1; fwd_addrB = 4'd4;
        push_pair(1'b1, 4'd1, 8'hA1, 1'b1, 4'd4, 8'hB1);
        push_pair(1'b1, 4'd1, 8'hA2, 1'b1, 4'd4, 8'hB2);
        push_pair(1'b1, 4'd1, 8'hA3, 1'b1, 4'd4, 8'hB3);
        idle(5);

        // illegal destination is acknowledged and dropped
        fwd_addrA = 4'd13;
        push_pair(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 8'h77);
        idle(3);

        // ten results through the ring with drains in between
        for (int k = 0; k < 10; k++) begin
            fwd_addrA = AW'(k % NUM_REGS);
            if (k % 2 == 0)
                push_pair(1'b1, AW'(k % NUM_REGS), DW'(8'h30 + k), 1'b0, 4'd0, 8'h00);
            else
                push_pair(1'b0, 4'd0, 8'h00, 1'b1, AW'(k % NUM_REGS), DW'(8'h30 + k));
            if (k % 3 == 2) idle(1);
        end
        idle(5);

        // reset with three entries pending
        push_pair(1'b1, 4'd5, 8'hC5, 1'b1, 4'd6, 8'hC6);
        push_pair(1'b1, 4'd7, 8'hC7, 1'b1, 4'd8, 8'hC8);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        idle(3);

        // randomized traffic with held offers and occasional reset
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!mem_valid || mem_acc) begin
                mem_valid = ($urandom_range(0, 99) < 55);
                mem_dest  = AW'($urandom_range(0, 13));
                mem_data  = DW'($urandom);
            end
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_dest  = AW'($urandom_range(0, 13));
                alu_data  = DW'($urandom);
            end
            fwd_addrA = AW'($urandom_range(0, 12));
            fwd_addrB = AW'($urandom_range(0, 12));
            Reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        Reset = 1'b0;
        mem_valid = 1'b0; alu_valid = 1'b0;
        idle(6);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
